// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match controller: move codes,
// round/match result codes, FSM state encoding and the move-beats-move rule.
package rps_pkg;

  localparam logic [1:0] MV_NONE     = 2'b00;
  localparam logic [1:0] MV_ROCK     = 2'b01;
  localparam logic [1:0] MV_PAPER    = 2'b10;
  localparam logic [1:0] MV_SCISSORS = 2'b11;

  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_COLLECT = 2'b01;
  localparam logic [1:0] ST_RESOLVE = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  // True when move a defeats move b; illegal codes never win.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == MV_ROCK)     && (b == MV_SCISSORS)) ||
           ((a == MV_SCISSORS) && (b == MV_PAPER))    ||
           ((a == MV_PAPER)    && (b == MV_ROCK));
  endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational round judge: compares the two latched moves and reports
// draw, player-1 win or player-2 win.
module rps_round_judge
  import rps_pkg::*;
(
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  output logic [1:0] result
);

  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = RES_DRAW;
    if (beats(p1_move, p2_move)) begin
      result = RES_P1;
    end else if (beats(p2_move, p1_move)) begin
      result = RES_P2;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: collects one legal move per player
// per round, judges the round, keeps score and declares the match winner.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9,
  parameter int SCORE_W    = 4
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         p1_move,
  input  logic               p1_valid,
  input  logic [1:0]         p2_move,
  input  logic               p2_valid,
  output logic               p1_ack,
  output logic               p2_ack,
  output logic [1:0]         move_err,
  output logic               round_done,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [7:0]         round_cnt,
  output logic               match_over,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
  localparam logic [7:0]         MAX_R = 8'(MAX_ROUNDS);

  logic [1:0]         state_q;
  logic [1:0]         got_q;
  logic [1:0]         mv_q [2];
  logic [1:0]         mv_in [2];
  logic [1:0]         valid_in;
  logic [1:0]         acc;
  logic [1:0]         err;
  logic               collecting;
  logic [1:0]         judge_res;
  logic [1:0]         res_q;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;
  logic [7:0]         cnt_next;

  assign mv_in[0] = p1_move;
  assign mv_in[1] = p2_move;
  assign valid_in = {p2_valid, p1_valid};

  // start wins over move acceptance, so no ack/err is raised in that cycle.
  assign collecting = (state_q == ST_COLLECT) && !start;

  always_comb begin
    acc = '0;
    err = '0;
    for (int i = 0; i < 2; i++) begin
      if (collecting && valid_in[i] && !got_q[i]) begin
        if (mv_in[i] == MV_NONE) err[i] = 1'b1;
        else                     acc[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      got_q <= '0;
      for (int i = 0; i < 2; i++) mv_q[i] <= MV_NONE;
    end else if (start || (state_q == ST_RESOLVE)) begin
      got_q <= '0;
      for (int i = 0; i < 2; i++) mv_q[i] <= MV_NONE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          got_q[i] <= 1'b1;
          mv_q[i]  <= mv_in[i];
        end
      end
    end
  end

  rps_round_judge u_judge (
    .p1_move (mv_q[0]),
    .p2_move (mv_q[1]),
    .result  (judge_res)
  );

  assign p1_next  = p1_score + SCORE_W'(judge_res == RES_P1);
  assign p2_next  = p2_score + SCORE_W'(judge_res == RES_P2);
  assign cnt_next = round_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      p1_score  <= '0;
      p2_score  <= '0;
      round_cnt <= '0;
      winner    <= RES_DRAW;
      res_q     <= RES_DRAW;
    end else if (start) begin
      state_q   <= ST_COLLECT;
      p1_score  <= '0;
      p2_score  <= '0;
      round_cnt <= '0;
      winner    <= RES_DRAW;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (&(got_q | acc)) state_q <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          res_q     <= judge_res;
          p1_score  <= p1_next;
          p2_score  <= p2_next;
          round_cnt <= cnt_next;
          if (p1_next == WIN_T) begin
            state_q <= ST_OVER;
            winner  <= RES_P1;
          end else if (p2_next == WIN_T) begin
            state_q <= ST_OVER;
            winner  <= RES_P2;
          end else if (cnt_next == MAX_R) begin
            state_q <= ST_OVER;
            if (p1_next > p2_next)      winner <= RES_P1;
            else if (p2_next > p1_next) winner <= RES_P2;
            else                        winner <= RES_DRAW;
          end else begin
            state_q <= ST_COLLECT;
          end
        end
        default: ;
      endcase
    end
  end

  assign p1_ack       = acc[0];
  assign p2_ack       = acc[1];
  assign move_err     = err;
  assign round_done   = (state_q == ST_RESOLVE);
  assign round_result = round_done ? judge_res : res_q;
  assign match_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Self-checking bench for rps_match_ctrl: directed match scenarios plus random
// traffic, all compared every cycle against a behavioural match model.
module tb_rps_match_ctrl;

  localparam int WT = 3;
  localparam int MR = 3;
  localparam int SW = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_PLAY = 1;
  localparam int PH_JUDGE = 2;
  localparam int PH_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    p1_move = 2'b00;
  logic          p1_valid = 1'b0;
  logic [1:0]    p2_move = 2'b00;
  logic          p2_valid = 1'b0;
  logic          p1_ack, p2_ack;
  logic [1:0]    move_err;
  logic          round_done;
  logic [1:0]    round_result;
  logic [SW-1:0] p1_score, p2_score;
  logic [7:0]    round_cnt;
  logic          match_over;
  logic [1:0]    winner;

  rps_match_ctrl #(.WIN_TARGET(WT), .MAX_ROUNDS(MR), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_move(p1_move), .p1_valid(p1_valid),
    .p2_move(p2_move), .p2_valid(p2_valid),
    .p1_ack(p1_ack), .p2_ack(p2_ack), .move_err(move_err),
    .round_done(round_done), .round_result(round_result),
    .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
    .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model of the match.
  int phase;
  int have [2];
  int mv [2];
  int sc [2];
  int rounds;
  int win;
  int last_res;
  bit exp_ack [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Moves 1..3 form a cycle where each code beats the one below it (mod 3):
  // (a-b) mod 3 is 0 for draw, 1 for p1 win, 2 for p2 win.
  function automatic int judge(input int a, input int b);
    return (a - b + 3) % 3;
  endfunction

  task automatic model_reset();
    phase = PH_IDLE;
    for (int i = 0; i < 2; i++) begin
      have[i] = 0; mv[i] = 0; sc[i] = 0;
    end
    rounds = 0; win = 0; last_res = 0;
  endtask

  task automatic compare_all();
    bit coll;
    bit v [2];
    int m [2];
    bit exp_err [2];
    coll = (phase == PH_PLAY) && !start;
    v[0] = p1_valid; v[1] = p2_valid;
    m[0] = int'(p1_move); m[1] = int'(p2_move);
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = coll && v[i] && (have[i] == 0) && (m[i] != 0);
      exp_err[i] = coll && v[i] && (have[i] == 0) && (m[i] == 0);
    end
    check("p1_ack", 32'(p1_ack), 32'(exp_ack[0]));
    check("p2_ack", 32'(p2_ack), 32'(exp_ack[1]));
    check("move_err", 32'(move_err), 32'({exp_err[1], exp_err[0]}));
    check("round_done", 32'(round_done), 32'(phase == PH_JUDGE));
    check("round_result", 32'(round_result),
          32'((phase == PH_JUDGE) ? judge(mv[0], mv[1]) : last_res));
    check("p1_score", 32'(p1_score), 32'(sc[0]));
    check("p2_score", 32'(p2_score), 32'(sc[1]));
    check("round_cnt", 32'(round_cnt), 32'(rounds));
    check("match_over", 32'(match_over), 32'(phase == PH_DONE));
    check("winner", 32'(winner), 32'(win));
  endtask

  task automatic model_step();
    int r;
    if (start) begin
      phase = PH_PLAY;
      for (int i = 0; i < 2; i++) begin
        have[i] = 0; sc[i] = 0;
      end
      rounds = 0; win = 0;
    end else if (phase == PH_PLAY) begin
      if (exp_ack[0]) begin have[0] = 1; mv[0] = int'(p1_move); end
      if (exp_ack[1]) begin have[1] = 1; mv[1] = int'(p2_move); end
      if (have[0] == 1 && have[1] == 1) phase = PH_JUDGE;
    end else if (phase == PH_JUDGE) begin
      r = judge(mv[0], mv[1]);
      last_res = r;
      if (r == 1) sc[0]++;
      if (r == 2) sc[1]++;
      rounds++;
      have[0] = 0; have[1] = 0;
      if (sc[0] == WT) begin
        phase = PH_DONE; win = 1;
      end else if (sc[1] == WT) begin
        phase = PH_DONE; win = 2;
      end else if (rounds == MR) begin
        phase = PH_DONE;
        win = (sc[0] > sc[1]) ? 1 : (sc[1] > sc[0]) ? 2 : 0;
      end else begin
        phase = PH_PLAY;
      end
    end
  endtask

  // One clock cycle: drive on the falling edge, compare 1 ns later, then
  // advance the model to the state after the next rising edge.
  task automatic cyc(input bit s, input bit v1, input logic [1:0] m1,
                     input bit v2, input logic [1:0] m2);
    @(negedge clk);
    rst = 1'b0; start = s;
    p1_valid = v1; p1_move = m1;
    p2_valid = v2; p2_move = m2;
    #1;
    compare_all();
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    p1_valid = 1'b0; p1_move = 2'b00;
    p2_valid = 1'b0; p2_move = 2'b00;
    #1;
    model_reset();
    compare_all();
  endtask

  task automatic play_round(input logic [1:0] a, input logic [1:0] b);
    cyc(0, 1, a, 1, b);
    cyc(0, 0, 2'b00, 0, 2'b00);
  endtask

  initial begin
    model_reset();
    do_reset();
    check("reset_round_cnt", 32'(round_cnt), 32'd0);
    check("reset_match_over", 32'(match_over), 32'd0);

    // p1 wins three rounds straight
    cyc(1, 0, 2'b00, 0, 2'b00);
    cyc(0, 1, 2'b01, 1, 2'b11);
    check("r1_acks", 32'({p2_ack, p1_ack}), 32'h3);
    cyc(0, 0, 2'b00, 0, 2'b00);
    check("r1_result", 32'({round_done, round_result}), 32'h5);
    play_round(2'b10, 2'b01);
    check("r2_result", 32'({round_done, round_result}), 32'h5);
    play_round(2'b11, 2'b10);
    check("r3_result", 32'({round_done, round_result}), 32'h5);
    cyc(0, 0, 2'b00, 0, 2'b00);
    check("win_p1_score", 32'(p1_score), 32'd3);
    check("win_over", 32'(match_over), 32'd1);
    check("win_winner", 32'(winner), 32'h1);

    // three draws hit the round cap
    cyc(1, 0, 2'b00, 0, 2'b00);
    play_round(2'b01, 2'b01);
    play_round(2'b10, 2'b10);
    play_round(2'b11, 2'b11);
    cyc(0, 0, 2'b00, 0, 2'b00);
    check("cap_scores", 32'({p2_score, p1_score}), 32'h0);
    check("cap_round_cnt", 32'(round_cnt), 32'd3);
    check("cap_over_winner", 32'({match_over, winner}), 32'h4);

    // illegal move, then simultaneous legal moves
    cyc(1, 0, 2'b00, 0, 2'b00);
    cyc(0, 1, 2'b00, 0, 2'b00);
    check("illegal_err", 32'(move_err), 32'h1);
    check("illegal_ack", 32'(p1_ack), 32'd0);
    cyc(0, 1, 2'b10, 1, 2'b01);
    check("both_acks", 32'({p2_ack, p1_ack}), 32'h3);
    cyc(0, 0, 2'b00, 0, 2'b00);
    check("both_result", 32'({round_done, round_result}), 32'h5);

    // second submission in one round is ignored
    cyc(0, 1, 2'b01, 0, 2'b00);
    cyc(0, 1, 2'b11, 0, 2'b00);
    check("resubmit_ack", 32'(p1_ack), 32'd0);
    cyc(0, 0, 2'b00, 1, 2'b11);
    cyc(0, 0, 2'b00, 0, 2'b00);
    check("resubmit_result", 32'({round_done, round_result}), 32'h5);

    // start during the resolve cycle aborts the round
    cyc(0, 1, 2'b10, 1, 2'b10);
    cyc(1, 0, 2'b00, 0, 2'b00);
    check("abort_done", 32'(round_done), 32'd1);
    cyc(0, 0, 2'b00, 0, 2'b00);
    check("abort_cleared", 32'({round_cnt, p2_score, p1_score}), 32'h0);
    play_round(2'b10, 2'b01);
    cyc(0, 0, 2'b00, 0, 2'b00);
    check("abort_next_cnt", 32'(round_cnt), 32'd1);

    // reset between p1 ack and p2 valid
    cyc(0, 1, 2'b01, 0, 2'b00);
    check("pre_rst_ack", 32'(p1_ack), 32'd1);
    do_reset();
    check("rst_outputs", 32'({round_cnt, p2_score, p1_score, match_over, winner, round_result}), 32'h0);
    cyc(0, 0, 2'b00, 1, 2'b10);
    check("post_rst_p2_ack", 32'(p2_ack), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 29) == 0,
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rps_match_ctrl.md
RPS_MATCH_CTRL -- requirements
Module: rps_match_ctrl

Interface
REQ-001 Parameter WIN_TARGET, default 3: round wins needed to take the match (1..15).
REQ-002 Parameter MAX_ROUNDS, default 9: hard cap on rounds per match, draws included (WIN_TARGET..255).
REQ-003 Parameter SCORE_W, default 4: width of score counters; SHALL satisfy 2**SCORE_W > WIN_TARGET.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse: clear scores and begin a match.
REQ-007 p1_move  in  2  player 1 move: 01 rock, 10 paper, 11 scissors, 00 illegal.
REQ-008 p1_valid  in  1  p1_move is presented this cycle.
REQ-009 p2_move / p2_valid  in  2 / 1  player 2 equivalents.
REQ-010 p1_ack / p2_ack  out  1  one-cycle pulse: the move was accepted.
REQ-011 move_err  out  2  one-cycle pulse per player (bit0 p1, bit1 p2): move rejected.
REQ-012 round_done  out  1  one-cycle pulse: a round was resolved.
REQ-013 round_result  out  2  00 draw, 01 p1 won, 10 p2 won; valid while round_done=1, held otherwise.
REQ-014 p1_score / p2_score  out  SCORE_W  running round wins.
REQ-015 round_cnt  out  8  rounds resolved in the current match.
REQ-016 match_over  out  1  level: the match has finished.
REQ-017 winner  out  2  00 tie, 01 p1, 10 p2; valid while match_over=1.

Function
REQ-018 FSM states: IDLE, COLLECT, RESOLVE, OVER.
REQ-019 IDLE: ignore moves (no ack, no err); start -> COLLECT, scores, round_cnt and winner cleared.
REQ-020 COLLECT: each player's move is latched at most once per round; on valid with a legal move, ack pulses the same cycle, and later valids from that player are ignored until the round resolves.
REQ-021 Move 00 with valid in COLLECT: move_err bit pulses, nothing latched, and the player may resubmit.
REQ-022 Both players valid in the same cycle: both are accepted independently.
REQ-023 COLLECT -> RESOLVE on the cycle after both moves are latched; RESOLVE lasts exactly one cycle.
REQ-024 RESOLVE: round_done=1; round_result is the judged result; the winner's score increments; round_cnt increments.
REQ-025 Judge: equal moves -> draw; rock beats scissors, scissors beats paper, paper beats rock.
REQ-026 After RESOLVE: if either score == WIN_TARGET -> OVER, with winner = that player.
REQ-027 Otherwise, if round_cnt == MAX_ROUNDS -> OVER, with winner = the higher score, or 00 if scores are equal.
REQ-028 Otherwise -> COLLECT, with the latched moves cleared.
REQ-029 OVER: match_over=1; outputs hold; moves ignored; start -> COLLECT with a cleared match.
REQ-030 start in COLLECT or RESOLVE: abort the match, clear all counters and latches, enter COLLECT. This takes priority over move acceptance and over scoring in the same cycle.
REQ-031 Scores never exceed WIN_TARGET and never wrap; round_cnt never exceeds MAX_ROUNDS.

Reset
REQ-032 rst asserted: state=IDLE immediately; all outputs 0 (scores, round_cnt, round_result, winner, match_over, ack, err, round_done).
REQ-033 Reset mid-round discards latched moves; the first legal activity after release is start.

Structure
REQ-034 Package rps_pkg SHALL hold the move codes (MV_NONE, MV_ROCK, MV_PAPER, MV_SCISSORS), the result codes (RES_DRAW, RES_P1, RES_P2), and the FSM state encoding.
REQ-035 Combinational sub-module rps_round_judge (p1_move, p2_move -> result[1:0]) SHALL implement REQ-025 and be instantiated once.
REQ-036 Per-player move latch logic SHALL be identical for both players (generate loop or shared code), with no duplicated special cases.

Verification
REQ-037 Defaults; start; rounds p1=01/p2=11, 10/01, 11/10 -> three round_done pulses, each result 01; p1_score=3; match_over=1, winner=01 after the third RESOLVE.
REQ-038 MAX_ROUNDS=3; three draws (01/01, 10/10, 11/11) -> p1_score=p2_score=0, round_cnt=3, match_over=1, winner=00.
REQ-039 p1 valid with move 00 -> move_err=01, no ack; then p1=10, p2=01 with valid in the same cycle -> both acks in one cycle; RESOLVE one cycle later with result 01.
REQ-040 p1 submits twice in one round (01, then 11) -> only the first is acked; result is based on 01.
REQ-041 rst pulse between p1 ack and p2 valid -> all outputs 0, state IDLE; a subsequent p2 valid without start -> no ack.
REQ-042 start asserted in the RESOLVE cycle -> scores and round_cnt read 0 on the next cycle; state COLLECT; round_done of that cycle not counted.
